mem_port_bram: RTL

On-chip block-RAM responder for the cache-line memory-port protocol, the protocol that the program cache, data cache and display controller use as initiators toward the SDRAM controller. It answers one initiator with fixed-length 4-word bursts and a programmable number of wait states. It serves as a scratchpad or boot memory on a spare port, or as a deterministic stand-in for the SDRAM controller in cache and display benches.

---
 rtl/mem_port_pkg.sv | 19 +
 rtl/mem_port_bram_if.sv | 33 +++
 rtl/bram_1rw.sv | 34 +++
 rtl/mem_port_bram.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared definitions for the cache-line memory-port protocol.
// Holds the responder FSM state type, line geometry and address width used
// by the interface, the BRAM responder and its benches.
package mem_port_pkg;

  localparam int unsigned MEM_LINE_WORDS = 4;
  localparam int unsigned MEM_OFFSET_W   = 2;
  localparam int unsigned MEM_ADDR_W     = 24;
  localparam int unsigned MEM_DATA_W     = 16;
  localparam int unsigned MEM_WAIT_W     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    BURST   = 2'd2,
    RECOVER = 2'd3
  } mem_port_state_t;

endpackage

// File: rtl/mem_port_bram_if.sv
// mem_port_bram_if: cache-line memory-port bundle.
//   mem_req      initiator -> responder, held until the 4th mem_ready
//   mem_wren     initiator -> responder, 1 = line write
//   mem_address  initiator -> responder, word address (bits [1:0] ignored)
//   to_mem       initiator -> responder, write data selected by mem_offset
//   from_mem     responder -> initiator, read data while mem_ready
//   mem_ready    responder -> initiator, one pulse per transferred word
//   mem_offset   responder -> initiator, word index within the line
//   err          responder -> initiator, sticky out-of-range flag
// Modports: master (initiator side), slave (responder side).
interface mem_port_bram_if;
  import mem_port_pkg::*;

  logic                    mem_req;
  logic                    mem_wren;
  logic [MEM_ADDR_W-1:0]   mem_address;
  logic [MEM_DATA_W-1:0]   to_mem;
  logic [MEM_DATA_W-1:0]   from_mem;
  logic                    mem_ready;
  logic [MEM_OFFSET_W-1:0] mem_offset;
  logic                    err;

  modport master (
    output mem_req, mem_wren, mem_address, to_mem,
    input  from_mem, mem_ready, mem_offset, err
  );

  modport slave (
    input  mem_req, mem_wren, mem_address, to_mem,
    output from_mem, mem_ready, mem_offset, err
  );

endinterface

// File: rtl/bram_1rw.sv
// bram_1rw: single-port synchronous RAM, one-cycle read latency,
// write-first (a write returns the new data on o_rdata next cycle).
//   clk      clock
//   i_we     write enable
//   i_addr   word address (AW bits)
//   i_wdata  write data (DW bits)
//   o_rdata  registered read data
// Contents are not affected by any reset.
module bram_1rw #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      r_rdata       <= i_wdata;
    end else begin
      r_rdata       <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_port_bram.sv
// mem_port_bram: block-RAM responder for the cache-line memory port.
// Answers one initiator with 4-word bursts after LATENCY wait cycles,
// followed by one RECOVER cycle (LATENCY+6 cycles per line).
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   mem_port_bram_if.slave (request/address/data/ready/offset/err)
// Parameters: ADDR_W (word-address bits served, 4..20),
//             LATENCY (wait cycles before the first mem_ready, 1..15).
// Optional: MEM_PORT_BRAM_RANGE_CHECK_EN -- requests with non-zero
// mem_address[23:ADDR_W] run normally but read 16'hFFFF, drop writes and
// set the sticky err flag. Without it upper bits alias and err is 0.
module mem_port_bram
  import mem_port_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_bram_if.slave   bus
);

  localparam int unsigned          LINE_W   = ADDR_W - MEM_OFFSET_W;
  localparam logic [MEM_WAIT_W-1:0] LAT_INIT = MEM_WAIT_W'(LATENCY);

  mem_port_state_t         r_state, w_next;
  logic [MEM_WAIT_W-1:0]   r_wait_cnt, w_wait_nxt;
  logic [LINE_W-1:0]       r_line;
  logic                    r_wren;
  logic                    r_oor;
  logic                    r_err;
  logic                    r_ready;
  logic [MEM_OFFSET_W-1:0] r_offset;

  logic                    w_accept;
  logic                    w_oor_req;
  logic                    w_in_burst;
  logic [MEM_OFFSET_W-1:0] w_ram_off;
  logic [ADDR_W-1:0]       w_ram_addr;
  logic                    w_ram_we;
  logic [MEM_DATA_W-1:0]   w_ram_q;

`ifdef MEM_PORT_BRAM_RANGE_CHECK_EN
  assign w_oor_req = |bus.mem_address[MEM_ADDR_W-1:ADDR_W];
`else
  assign w_oor_req = 1'b0;
`endif

  assign w_accept   = (r_state == IDLE) && bus.mem_req;
  assign w_in_burst = (r_state == BURST);

  // Next-state / wait-counter logic.
  always_comb begin
    w_next     = r_state;
    w_wait_nxt = r_wait_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.mem_req) begin
          w_next     = WAIT;
          w_wait_nxt = LAT_INIT;
        end
      end
      WAIT: begin
        if (r_wait_cnt == MEM_WAIT_W'(1)) w_next = BURST;
        else                              w_wait_nxt = r_wait_cnt - MEM_WAIT_W'(1);
      end
      BURST: begin
        if (r_offset == MEM_OFFSET_W'(MEM_LINE_WORDS - 1)) w_next = RECOVER;
      end
      RECOVER: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_line     <= '0;
      r_wren     <= 1'b0;
      r_oor      <= 1'b0;
      r_err      <= 1'b0;
      r_ready    <= 1'b0;
      r_offset   <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
      if (w_accept) begin
        r_line <= bus.mem_address[ADDR_W-1:MEM_OFFSET_W];
        r_wren <= bus.mem_wren;
        r_oor  <= w_oor_req;
      end
      r_err    <= r_err | (w_accept & w_oor_req);
      r_ready  <= (w_next == BURST);
      r_offset <= w_in_burst ? r_offset + MEM_OFFSET_W'(1) : '0;
    end
  end

  // Reads run one word ahead so the registered RAM output lines up with
  // r_offset; outside BURST the address parks on word 0, which makes the
  // last WAIT cycle fetch the first word. Writes use the current offset.
  always_comb begin
    w_ram_off = '0;
    if (w_in_burst) begin
      w_ram_off = r_wren ? r_offset : r_offset + MEM_OFFSET_W'(1);
    end
  end

  assign w_ram_addr = {r_line, w_ram_off};
  assign w_ram_we   = w_in_burst & r_wren & ~r_oor;

  bram_1rw #(
    .AW (ADDR_W),
    .DW (MEM_DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (bus.to_mem),
    .o_rdata (w_ram_q)
  );

  // Output data is a select between registers only (RAM output, burst
  // flags), so there is no path from the bus inputs; gating with r_ready
  // gives 0 out of reset since the RAM output itself is not reset.
  assign bus.from_mem   = (r_ready && !r_wren) ? (r_oor ? '1 : w_ram_q) : '0;
  assign bus.mem_ready  = r_ready;
  assign bus.mem_offset = r_offset;
  assign bus.err        = r_err;

endmodule
